// File: rtl/dmem_responder.sv
// Byte-wide memory that serves 32-bit big-endian word requests one byte per cycle.
// Optional alignment checking: define DMEM_RESPONDER_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          k_reg;
  logic                write_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [7:0]          rd_byte_reg;
  logic                pend_reg;
  logic [1:0]          pend_k_reg;
  logic [31:0]         rsp_rdata_reg;
  logic                rsp_err_reg;
  logic                rsp_valid_reg;

  logic [7:0]          mem [DEPTH];

  logic                accept;
  logic                misalign;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic                mem_re;
  logic [7:0]          wr_byte;

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  assign misalign = (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign accept    = (state_reg == IDLE) && req_valid;
  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  // Byte k is the k-th most significant byte of the word; address wraps mod DEPTH.
  assign mem_addr = addr_reg + ADDR_W'(k_reg);
  assign mem_we   = (state_reg == XFER) && write_reg && rst_n;
  assign mem_re   = (state_reg == XFER) && !write_reg;

  always_comb begin
    wr_byte = 8'h00;
    case (k_reg)
      2'd0: wr_byte = wdata_reg[31:24];
      2'd1: wr_byte = wdata_reg[23:16];
      2'd2: wr_byte = wdata_reg[15:8];
      2'd3: wr_byte = wdata_reg[7:0];
      default: wr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= wr_byte;
    else if (mem_re)
      rd_byte_reg <= mem[mem_addr];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = misalign ? RESP : XFER;
      XFER: if (k_reg == 2'd3) state_next = RESP;
      RESP: if (rsp_valid_reg && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read bytes arrive one cycle after their access, so the last slice lands on
  // the first RESP cycle, the same edge that raises rsp_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      k_reg         <= 2'd0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= 32'h0;
      pend_reg      <= 1'b0;
      pend_k_reg    <= 2'd0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pend_reg   <= mem_re;
      pend_k_reg <= k_reg;
      if (accept) begin
        write_reg     <= req_write;
        addr_reg      <= req_addr;
        wdata_reg     <= req_wdata;
        k_reg         <= 2'd0;
        rsp_rdata_reg <= 32'h0;
        rsp_err_reg   <= misalign;
      end
      if (state_reg == XFER)
        k_reg <= k_reg + 2'd1;
      if (pend_reg) begin
        case (pend_k_reg)
          2'd0: rsp_rdata_reg[31:24] <= rd_byte_reg;
          2'd1: rsp_rdata_reg[23:16] <= rd_byte_reg;
          2'd2: rsp_rdata_reg[15:8]  <= rd_byte_reg;
          default: rsp_rdata_reg[7:0] <= rd_byte_reg;
        endcase
      end
      if (state_reg == RESP) begin
        if (!rsp_valid_reg)
          rsp_valid_reg <= 1'b1;
        else if (rsp_ready)
          rsp_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array model.
// Honours DMEM_RESPONDER_ALIGN_CHECK_EN when the build defines it.
module tb_dmem_responder;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  int total = 0;
  int bad = 0;
  logic [7:0] model [DEPTH];

  dmem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
  endtask

  task automatic do_txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] rdata_o);
    logic [31:0] rd_exp;
    bit          err_exp;
    int          lat;
    bit          got;
    logic [31:0] held;
    err_exp = 1'b0;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    err_exp = (a[1:0] != 2'b00);
`endif
    rd_exp = 32'h0;
    if (!err_exp) begin
      for (int k = 0; k < 4; k++) begin
        if (wr) model[(int'(a) + k) % DEPTH] = wd[31-8*k -: 8];
        else    rd_exp[31-8*k -: 8] = model[(int'(a) + k) % DEPTH];
      end
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    check_val("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // scramble the request inputs; a live transaction must ignore them
    req_write = $urandom_range(0, 1) == 1;
    req_addr  = ADDR_W'($urandom);
    req_wdata = $urandom;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check_val("latency", 32'(lat), err_exp ? 32'd1 : 32'd5);
    rdata_o = rsp_rdata;
    if (!got) begin
      req_valid = 1'b0;
      return;
    end
    check_val("rdata", rsp_rdata, rd_exp);
    check_val("err", 32'(rsp_err), 32'(err_exp));
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_rdata", rsp_rdata, held);
      check_val("hold_err", 32'(rsp_err), 32'(err_exp));
      check_val("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_val("post_valid", 32'(rsp_valid), 32'd0);
    check_val("post_ready", 32'(req_ready), 32'd1);
    $display("txn %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d hold=%0d",
             wr ? "WR" : "RD", a, wd, held, rsp_err, lat, hold);
  endtask

  initial begin
    logic [31:0] r;
    do_reset();

    // Fill the whole array so the model is fully known.
    for (int w = 0; w < DEPTH / 4; w++)
      do_txn(1'b1, ADDR_W'(w * 4), $urandom, 0, r);

    do_reset();
    for (int w = 0; w < 6; w++)
      do_txn(1'b0, ADDR_W'($urandom_range(0, DEPTH / 4 - 1) * 4), 32'h0, 0, r);

    do_txn(1'b1, 7'h10, 32'hDEADBEEF, 0, r);
    do_txn(1'b0, 7'h10, 32'h0, 3, r);
    check_val("deadbeef", r, 32'hDEADBEEF);

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    do_txn(1'b1, 7'h05, 32'h55667788, 0, r);
    do_txn(1'b0, 7'h04, 32'h0, 0, r);
    do_txn(1'b0, 7'h08, 32'h0, 0, r);
`else
    do_txn(1'b1, 7'h7E, 32'h11223344, 0, r);
    do_txn(1'b0, 7'h7E, 32'h0, 1, r);
    check_val("wrap_read", r, 32'h11223344);
    do_txn(1'b0, 7'h7C, 32'h0, 0, r);
    check_val("wrap_low", r[15:0], 32'h1122);
    do_txn(1'b0, 7'h00, 32'h0, 0, r);
    check_val("wrap_high", r[31:16], 32'h3344);
`endif

    // Reset lands at acceptance+3 of a write: two bytes written, no response.
    do_txn(1'b1, 7'h20, 32'h0, 0, r);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'h20;
    req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model[8'h20] = 8'hAA;
    model[8'h21] = 8'hBB;
    check_val("abort_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    $display("txn ABORT addr=20 wdata=aabbccdd");
    do_txn(1'b0, 7'h20, 32'h0, 0, r);
    check_val("abort_bytes", r, 32'hAABB0000);

    for (int i = 0; i < 60; i++)
      do_txn($urandom_range(0, 1) == 1, ADDR_W'($urandom), $urandom, $urandom_range(0, 3), r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
